// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack controller.
//   - Command encodings carried on the op bus.
//   - Pointer FSM state type.
package lifo_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'b00,
    S_ACTIVE = 2'b01,
    S_FULL   = 2'b10
  } state_t;

endpackage

// File: rtl/lifo_stack_ctrl_if.sv
// Command/result bundle between the command decoder and the LIFO controller.
//   master : decoder side  - drives en/op/din, observes results and status
//   slave  : stack side    - consumes en/op/din, drives dout/dout_valid,
//                            count/empty/full, overflow/underflow/err
interface lifo_stack_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              en;
  logic [1:0]        op;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic              err;

  modport master (
    output en, op, din,
    input  dout, dout_valid, count, empty, full, overflow, underflow, err
  );

  modport slave (
    input  en, op, din,
    output dout, dout_valid, count, empty, full, overflow, underflow, err
  );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x DATA_W register file for the LIFO stack.
//   i_clk      : write clock
//   i_we       : write enable (successful push only)
//   i_wr_addr  : write slot
//   i_wr_data  : word to store
//   i_rd_addr  : combinational read slot (top of stack)
//   o_rd_data  : word at i_rd_addr
// Contents are not reset.
module stack_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack controller.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of lifo_stack_ctrl_if
//            en/op/din in; dout/dout_valid, count/empty/full,
//            overflow/underflow pulses and sticky err out.
// One command per cycle; all outputs registered. empty/full decode
// directly from the FSM state, which tracks count.
module lifo_stack_ctrl
  import lifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  lifo_stack_ctrl_if.slave   bus
);

  localparam int unsigned    CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

  state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_count,  w_count_nxt;
  logic [DATA_W-1:0] r_dout,   w_dout_nxt;
  logic              r_dv,     w_dv_nxt;
  logic              r_ovf,    w_ovf_nxt;
  logic              r_unf,    w_unf_nxt;
  logic              r_err,    w_err_nxt;

  logic              w_push_ok;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_push_ok = bus.en && (bus.op == OP_PUSH) && (r_state != S_FULL);
  // Push never happens at count==DEPTH, so the slot index fits in AW bits.
  assign w_wr_addr = AW'(r_count);
  // Wraps when empty; the read result is only consumed when not empty.
  assign w_rd_addr = AW'(r_count - 1'b1);

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk     (clk),
    .i_we      (w_push_ok),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.din),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_dv    <= w_dv_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_dv_nxt    = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    w_err_nxt   = r_err;

    if (bus.en) begin
      unique case (bus.op)
        OP_PUSH: begin
          if (r_state == S_FULL) begin
            w_ovf_nxt = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + 1'b1;
            w_state_nxt = (w_count_nxt == LP_DEPTH) ? S_FULL : S_ACTIVE;
          end
        end
        OP_POP: begin
          if (r_state == S_EMPTY) begin
            w_unf_nxt = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_dout_nxt  = w_rd_data;
            w_dv_nxt    = 1'b1;
            w_count_nxt = r_count - 1'b1;
            w_state_nxt = (w_count_nxt == '0) ? S_EMPTY : S_ACTIVE;
          end
        end
        OP_PEEK: begin
          if (r_state == S_EMPTY) begin
            w_unf_nxt = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_dout_nxt = w_rd_data;
            w_dv_nxt   = 1'b1;
          end
        end
        default: begin
          w_count_nxt = '0;
          w_state_nxt = S_EMPTY;
          w_err_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dv;
  assign bus.count      = r_count;
  assign bus.empty      = (r_state == S_EMPTY);
  assign bus.full       = (r_state == S_FULL);
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_unf;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Bench for lifo_stack_ctrl: directed scenarios followed by random
// commands, all compared against a queue-based model of the stack.
module tb_lifo_stack_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lifo_stack_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lifo_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_dv   = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_unf  = 1'b0;
  logic              m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic rst, input logic e, input logic [1:0] o,
                             input logic [DATA_W-1:0] d);
    if (!rst) begin
      m_q.delete();
      m_dout = '0;
      m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    end else begin
      m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      if (e) begin
        case (o)
          2'b00: if (m_q.size() == DEPTH) begin m_ovf = 1'b1; m_err = 1'b1; end
                 else m_q.push_back(d);
          2'b01: if (m_q.size() == 0) begin m_unf = 1'b1; m_err = 1'b1; end
                 else begin m_dout = m_q.pop_back(); m_dv = 1'b1; end
          2'b10: if (m_q.size() == 0) begin m_unf = 1'b1; m_err = 1'b1; end
                 else begin m_dout = m_q[$]; m_dv = 1'b1; end
          default: begin m_q.delete(); m_err = 1'b0; end
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(bus.count), m_q.size());
    chk({tag, "_empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
    chk({tag, "_full"},  32'(bus.full),  32'(m_q.size() == DEPTH));
    chk({tag, "_dout"},  32'(bus.dout),  32'(m_dout));
    chk({tag, "_dv"},    32'(bus.dout_valid), 32'(m_dv));
    chk({tag, "_ovf"},   32'(bus.overflow),   32'(m_ovf));
    chk({tag, "_unf"},   32'(bus.underflow),  32'(m_unf));
    chk({tag, "_err"},   32'(bus.err),        32'(m_err));
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled at that point.
  task automatic step(input string tag, input logic rst, input logic e,
                      input logic [1:0] o, input logic [DATA_W-1:0] d);
    rst_n   = rst;
    bus.en  = e;
    bus.op  = o;
    bus.din = d;
    @(posedge clk);
    model_apply(rst, e, o, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    logic [1:0] o;
    bus.en = 1'b0; bus.op = 2'b00; bus.din = '0;
    #1;

    // Reset state
    step("rst0", 1'b0, 1'b1, 2'b00, 8'h77);
    step("rst1", 1'b0, 1'b0, 2'b00, 8'h00);

    // Push 3 then pop 3
    step("tp1_push", 1'b1, 1'b1, 2'b00, 8'h11);
    step("tp1_push", 1'b1, 1'b1, 2'b00, 8'h22);
    step("tp1_push", 1'b1, 1'b1, 2'b00, 8'h33);
    chk("tp1_cnt3", 32'(bus.count), 3);
    step("tp1_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    chk("tp1_top", 32'(bus.dout), 32'h33);
    step("tp1_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    chk("tp1_mid", 32'(bus.dout), 32'h22);
    step("tp1_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    chk("tp1_bot", 32'(bus.dout), 32'h11);
    chk("tp1_empty", 32'(bus.empty), 1);

    // Fill, overflow, pop top
    for (int i = 0; i < int'(DEPTH); i++)
      step("tp2_fill", 1'b1, 1'b1, 2'b00, 8'(8'hC0 + i));
    chk("tp2_full", 32'(bus.full), 1);
    step("tp2_ovf", 1'b1, 1'b1, 2'b00, 8'hAA);
    chk("tp2_ovf_pulse", 32'(bus.overflow), 1);
    step("tp2_ovf_drop", 1'b1, 1'b0, 2'b00, 8'h00);
    chk("tp2_ovf_low", 32'(bus.overflow), 0);
    step("tp2_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    chk("tp2_top", 32'(bus.dout), 32'hC4);

    // Underflow from reset, peek underflow, clear
    step("tp3_rst", 1'b0, 1'b0, 2'b00, 8'h00);
    step("tp3_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    chk("tp3_unf", 32'(bus.underflow), 1);
    step("tp3_peek", 1'b1, 1'b1, 2'b10, 8'h00);
    step("tp3_clr", 1'b1, 1'b1, 2'b11, 8'h00);
    chk("tp3_err_clr", 32'(bus.err), 0);

    // Peek twice, then idle
    step("tp4_push", 1'b1, 1'b1, 2'b00, 8'h5A);
    step("tp4_peek", 1'b1, 1'b1, 2'b10, 8'h00);
    step("tp4_peek", 1'b1, 1'b1, 2'b10, 8'h00);
    chk("tp4_dout", 32'(bus.dout), 32'h5A);
    for (int i = 0; i < 3; i++)
      step("tp4_idle", 1'b1, 1'b0, 2'($urandom), 8'($urandom));

    // Reset overrides a push
    step("tp5_clr", 1'b1, 1'b1, 2'b11, 8'h00);
    for (int i = 0; i < 3; i++)
      step("tp5_push", 1'b1, 1'b1, 2'b00, 8'(8'h40 + i));
    step("tp5_rst", 1'b0, 1'b1, 2'b00, 8'h99);
    chk("tp5_cnt0", 32'(bus.count), 0);
    step("tp5_pop", 1'b1, 1'b1, 2'b01, 8'h00);

    // Full-rate push/pop alternation
    step("tp6_clr", 1'b1, 1'b1, 2'b11, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("tp6_push", 1'b1, 1'b1, 2'b00, 8'h01);
      step("tp6_pop", 1'b1, 1'b1, 2'b01, 8'h00);
    end
    chk("tp6_err", 32'(bus.err), 0);

    // Random commands, occasional reset
    for (int i = 0; i < 600; i++) begin
      v = 8'($urandom);
      o = 2'($urandom);
      if (($urandom % 4) == 0) o = 2'b00;
      if (o == 2'b11 && ($urandom % 3) != 0) o = 2'b01;
      step("rnd", ($urandom % 60) != 0, ($urandom % 8) != 0, o, v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
